floo_mcast_fork_ctrl: RTL and testbench

Multicast fork controller for one router input virtual channel. It sits between an input FIFO / route-select stage and the per-output wormhole arbiters. It takes an output route mask at each packet head, locks that mask for the whole wormhole packet, and presents each flit to every selected output. Each output accepts the flit independently (eager fork), and the flit retires only when all selected outputs have taken it. It also drops empty-mask heads with an error flag and reports per-flit stall time.

---
 rtl/floo_mcast_fork_ctrl.sv | 99 +++++++++
 tb/tb_floo_mcast_fork_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/floo_mcast_fork_ctrl.sv
// Multicast fork controller: locks the route mask per wormhole packet and
// retires each flit once every selected output has eagerly accepted it.
module floo_mcast_fork_ctrl #(
  parameter int unsigned NumOutput     = 5,
  parameter type         flit_t        = logic,
  parameter int unsigned StallCntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  flit_t                    data_i,
  input  logic                     last_i,
  input  logic [NumOutput-1:0]     sel_i,
  output logic [NumOutput-1:0]     valid_o,
  input  logic [NumOutput-1:0]     ready_i,
  output flit_t                    data_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [StallCntWidth-1:0] stall_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [NumOutput-1:0]     sel_q, sel_d;
  logic [NumOutput-1:0]     sent_q, sent_d;
  logic                     err_q, err_d;
  logic [StallCntWidth-1:0] stall_q, stall_d;

  logic [NumOutput-1:0] eff_sel;
  logic [NumOutput-1:0] acc;
  logic                 done;
  logic                 hs;
  logic                 empty_head;

  always_comb begin
    eff_sel    = (state_q == IDLE) ? sel_i : sel_q;
    valid_o    = {NumOutput{valid_i}} & eff_sel & ~sent_q;
    acc        = valid_o & ready_i;
    // An empty mask leaves every bit of ~eff_sel set, so the flit drops through.
    done       = &(sent_q | acc | ~eff_sel);
    ready_o    = valid_i & done;
    hs         = ready_o;
    empty_head = (state_q == IDLE) && (sel_i == '0);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sent_d  = sent_q | acc;
    err_d   = valid_i & empty_head;
    stall_d = stall_q;

    if (hs) begin
      sent_d  = '0;
      stall_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!empty_head && !last_i) begin
            state_d = BODY;
            sel_d   = sel_i;
          end
        end
        BODY: begin
          if (last_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (valid_i && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign data_o      = data_i;
  assign busy_o      = (state_q == BODY) | (|sent_q);
  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_floo_mcast_fork_ctrl.sv
// Directed bench for floo_mcast_fork_ctrl: vector table plus hand-written
// sequences for stall saturation and reset in the middle of a packet.
module tb_floo_mcast_fork_ctrl;

  localparam int unsigned N  = 5;
  localparam int unsigned SW = 4;
  typedef logic [7:0] flit_t;

  logic          clk, rst;
  logic          valid_i, ready_o, last_i;
  flit_t         data_i, data_o;
  logic [N-1:0]  sel_i, valid_o, ready_i;
  logic          busy_o, err_o;
  logic [SW-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  floo_mcast_fork_ctrl #(
    .NumOutput    (N),
    .flit_t       (flit_t),
    .StallCntWidth(SW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .last_i     (last_i),
    .sel_i      (sel_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream must hold a partially delivered flit stable until it retires.
  logic  pend;
  flit_t pend_data;
  logic  pend_last;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        assert (valid_i && data_i == pend_data && last_i == pend_last)
          else $error("upstream changed a partially delivered flit");
      end
      pend      <= valid_i & ~ready_o & (pend | (|(valid_o & ready_i)));
      pend_data <= data_i;
      pend_last <= last_i;
    end
  end

  typedef struct {
    string        name;
    logic         v;
    logic         l;
    logic [N-1:0] sel;
    logic [N-1:0] rdy;
    flit_t        d;
    logic [N-1:0] e_vo;
    logic         e_ro;
    logic         e_busy;
    logic         e_err;
    int           e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [N-1:0] s,
                       input logic [N-1:0] r, input flit_t d);
    valid_i = v; last_i = l; sel_i = s; ready_i = r; data_i = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic v, input logic l,
                     input logic [N-1:0] s, input logic [N-1:0] r, input flit_t d,
                     input logic [N-1:0] evo, input logic ero, input logic eb,
                     input logic ee, input int es);
    vec_t t;
    t.name = n; t.v = v; t.l = l; t.sel = s; t.rdy = r; t.d = d;
    t.e_vo = evo; t.e_ro = ero; t.e_busy = eb; t.e_err = ee; t.e_stall = es;
    vecs.push_back(t);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 8'h00);
    pend_data = '0; pend_last = 1'b0;

    // name, v, l, sel, rdy, data | valid_o, ready_o, busy, err, stall
    add("idle",        0, 0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 0);
    add("uni",         1, 1, 5'b00100, 5'b11111, 8'h11, 5'b00100, 1, 0, 0, 0);
    add("uni_after",   0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0, 0);
    add("mc_c0",       1, 1, 5'b01101, 5'b11011, 8'h22, 5'b01101, 0, 0, 0, 0);
    add("mc_c1",       1, 1, 5'b01101, 5'b11011, 8'h22, 5'b00100, 0, 1, 0, 1);
    add("mc_c2",       1, 1, 5'b01101, 5'b11011, 8'h22, 5'b00100, 0, 1, 0, 2);
    add("mc_c3",       1, 1, 5'b01101, 5'b11111, 8'h22, 5'b00100, 1, 1, 0, 3);
    add("mc_after",    0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0, 0);
    add("pkt_head",    1, 0, 5'b00110, 5'b11111, 8'h31, 5'b00110, 1, 0, 0, 0);
    add("pkt_body",    1, 0, 5'b00001, 5'b11111, 8'h32, 5'b00110, 1, 1, 0, 0);
    add("pkt_tail",    1, 1, 5'b00001, 5'b11111, 8'h33, 5'b00110, 1, 1, 0, 0);
    add("pkt_next",    1, 1, 5'b00001, 5'b11111, 8'h34, 5'b00001, 1, 0, 0, 0);
    add("empty_head",  1, 1, 5'b00000, 5'b11111, 8'h40, 5'b00000, 1, 0, 0, 0);
    add("empty_err",   0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 1, 0);
    add("empty_clr",   0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0, 0);
    add("empty_nolst", 1, 0, 5'b00000, 5'b11111, 8'h50, 5'b00000, 1, 0, 0, 0);
    add("rehead",      1, 1, 5'b01000, 5'b11111, 8'h51, 5'b01000, 1, 0, 1, 0);
    add("body_part0",  1, 0, 5'b00011, 5'b00001, 8'h61, 5'b00011, 0, 0, 0, 0);
    add("body_part1",  1, 0, 5'b00011, 5'b00010, 8'h61, 5'b00010, 1, 1, 0, 1);
    add("body_tail",   1, 1, 5'b11100, 5'b11111, 8'h62, 5'b00011, 1, 1, 0, 0);
    add("body_done",   0, 0, 5'b00000, 5'b11111, 8'h00, 5'b00000, 0, 0, 0, 0);

    // Behaviour while reset is held.
    #2;
    drive(1'b1, 1'b1, 5'b00011, 5'b00001, 8'hAA);
    #1;
    chk("rst_valid_o", valid_o, 5'b00011);
    chk("rst_ready_o", ready_o, 0);
    chk("rst_busy",    busy_o, 0);
    chk("rst_err",     err_o, 0);
    chk("rst_stall",   stall_cnt_o, 0);
    drive(1'b0, 1'b0, '0, '0, 8'h00);
    next_cycle();
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].l, vecs[i].sel, vecs[i].rdy, vecs[i].d);
      #3;
      chk({vecs[i].name, ".valid_o"}, valid_o, vecs[i].e_vo);
      chk({vecs[i].name, ".ready_o"}, ready_o, vecs[i].e_ro);
      chk({vecs[i].name, ".busy"},    busy_o, vecs[i].e_busy);
      chk({vecs[i].name, ".err"},     err_o, vecs[i].e_err);
      chk({vecs[i].name, ".stall"},   stall_cnt_o, vecs[i].e_stall);
      chk({vecs[i].name, ".data"},    data_o, vecs[i].d);
      next_cycle();
    end

    // Saturation: flit held unaccepted for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 5'b00001, 5'b00000, 8'h70);
      #3;
      chk($sformatf("sat_c%0d", k), stall_cnt_o, (k < 15) ? k : 15);
      chk($sformatf("sat_ro%0d", k), ready_o, 0);
      next_cycle();
    end
    drive(1'b1, 1'b1, 5'b00001, 5'b00001, 8'h70);
    #3;
    chk("sat_hs_ro",    ready_o, 1);
    chk("sat_hs_stall", stall_cnt_o, 15);
    next_cycle();
    drive(1'b0, 1'b0, '0, 5'b11111, 8'h00);
    #3;
    chk("sat_clr", stall_cnt_o, 0);
    next_cycle();

    // Reset in the middle of a packet.
    drive(1'b1, 1'b0, 5'b10000, 5'b11111, 8'h80);
    #3;
    chk("mid_head_ro", ready_o, 1);
    chk("mid_head_vo", valid_o, 5'b10000);
    next_cycle();
    drive(1'b0, 1'b0, '0, 5'b11111, 8'h00);
    #1;
    chk("mid_busy_pre", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy_rst", busy_o, 0);
    rst = 1'b0;
    next_cycle();
    drive(1'b1, 1'b1, 5'b00010, 5'b11111, 8'h81);
    #3;
    chk("mid_next_vo", valid_o, 5'b00010);
    chk("mid_next_ro", ready_o, 1);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 8'h00);
    #3;
    chk("mid_final_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
